hazard_stall_controller: RTL
============================

# hazard_stall_controller

Sequences pipeline stalls for the five-stage MIPS core: detects load-use and ID-stage branch-operand hazards, holds PC and IF/ID, and drives `IDStall` into the ID-stage stalling mux, which zeroes the control word to inject a bubble into ID/EX. It also freezes the whole pipeline while the data memory/cache reports busy, and flushes IF on taken branches and jumps. A saturating counter records stall cycles for performance measurement.

## Interface
- `REG_W`, 5: register-specifier width.
- `CNT_W`, 16: stall-cycle counter width.

- `Clk` in 1: clock; all state updates on the rising edge.
- `Rst` in 1: synchronous, active-high reset.
- `RsID`, `RtID` in REG_W: source registers of the instruction in ID.
- `UsesRs`, `UsesRt` in 1: the ID instruction actually reads rs / rt.
- `IDBranch` in 1: the ID instruction compares operands in ID (beq/bne/bgez/…/jr).
- `BranchTaken` in 1: the ID branch or jump redirects the PC this cycle.
- `EXDest`, `MEMDest` in REG_W: destination registers in EX and MEM.
- `EXRegWrite`, `MEMRegWrite` in 1: EX / MEM instruction writes the register file.
- `EXMemRead`, `MEMMemRead` in 2: load-size encoding; any nonzero value marks a load.
- `MemBusy` in 1: the data memory/cache cannot complete this cycle.
- `PCWrite` out 1: PC load enable.
- `IFIDWrite` out 1: IF/ID register enable.
- `IDStall` out 1: to the stalling mux; 1 zeroes the ID/EX control word.
- `PipeEn` out 1: global enable for ID/EX, EX/MEM and MEM/WB.
- `IFFlush` out 1: clears IF/ID on the next edge.
- `StallCycles` out CNT_W: saturating count of cycles with `IDStall`=1.

## Operation
- hitEX(r) = r≠0 & r==EXDest & EXRegWrite. hitMEM(r) = r≠0 & r==MEMDest & MEMRegWrite. Each is evaluated for rs when UsesRs and for rt when UsesRt. Register $0 never causes a hazard.
- Required stall count `need` is the maximum of the following:
  - EX load (EXMemRead≠0) & hitEX: 1.
  - IDBranch & hitEX & EX not a load: 1.
  - IDBranch & hitEX & EX load: 2.
  - IDBranch & hitMEM & MEM load: 1.
  - Otherwise: 0.
- The state machine has three states: RUN, STALL (holds 1-bit `remain`) and FREEZE.
- RUN:
  - MemBusy → FREEZE. Hazard evaluation is suppressed.
  - Else if need≥1: IDStall=1 this cycle (combinational). If need=2, go to STALL with remain=1. If need=1, stay in RUN.
  - Else: normal flow.
- STALL: IDStall=1 and hazard inputs are ignored.
  - MemBusy → FREEZE, keeping `remain`.
  - Else if remain=1 → RUN.
- FREEZE:
  - PipeEn=0, PCWrite=0, IFIDWrite=0, IDStall=0, IFFlush=0.
  - When MemBusy falls, return to the saved state (RUN, or STALL with the saved remain).
  - The saved state is held in a 1-bit `ret` register.
- Outputs by condition:
  - Stalled: PCWrite=0, IFIDWrite=0, PipeEn=1, IFFlush=0.
  - Normal: PCWrite=1, IFIDWrite=1, PipeEn=1, IDStall=0, IFFlush=BranchTaken.
- BranchTaken is ignored while stalled or frozen; it is re-sampled once the branch is hazard-free.
- StallCycles increments by 1 on each edge where IDStall=1. It saturates at 2^CNT_W−1 and is cleared only by reset.
- Priority order: Rst > MemBusy > STALL countdown > new hazard > flush.

## Timing
- Reset, applied and sampled at the edge:
  - State goes to RUN; remain=0; ret=RUN; StallCycles=0.
  - While Rst=1, outputs are forced to PCWrite=1, IFIDWrite=1, PipeEn=1, IDStall=0, IFFlush=0.
- Detection is combinational, so there is zero-cycle latency from hazard to IDStall in RUN. A 2-cycle stall asserts IDStall on two consecutive non-frozen cycles.
- Reset in mid-STALL or mid-FREEZE abandons the pending stall. The first cycle after reset re-evaluates hazards from RUN.
- A MemBusy rising edge in the same cycle as a new hazard: FREEZE wins. The hazard is re-detected after MemBusy falls; no bubble is inserted during the freeze.
- FREEZE does not advance `remain` and does not increment StallCycles.
- MemBusy held for N cycles yields exactly N cycles of PipeEn=0.

## Test plan
- Load-use: EX=`lw $5`, ID=`add $6,$5,$7` (UsesRs) → IDStall=1, PCWrite=0 for exactly 1 cycle; next cycle (EX bubble) IDStall=0; StallCycles=1.
- Branch after load: EX=`lw $4`, ID=`beq $4,$0` (IDBranch) → IDStall=1 for 2 consecutive cycles, then IFFlush=1 in the following cycle if BranchTaken; StallCycles=2.
- $0 and unused operands: EXDest=0 with load, RsID=0 → no stall. RtID matches but UsesRt=0 → no stall.
- Freeze mid-stall: trigger a 2-cycle stall, raise MemBusy after cycle 1 for 3 cycles → PipeEn=0 for 3 cycles, then exactly 1 more IDStall cycle; StallCycles=2.
- Reset mid-STALL: assert Rst during remain=1 → next cycle all outputs are at reset values and StallCycles=0. Separately, with CNT_W=2 and 5 stall cycles, StallCycles stops at 3.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Pipeline stall sequencer for the five-stage MIPS core: load-use and ID-branch
// operand hazards, data-memory freeze, IF flush on redirect, and a stall-cycle counter.
module hazard_stall_controller #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [REG_W-1:0] RsID,
    input  logic [REG_W-1:0] RtID,
    input  logic             UsesRs,
    input  logic             UsesRt,
    input  logic             IDBranch,
    input  logic             BranchTaken,
    input  logic [REG_W-1:0] EXDest,
    input  logic [REG_W-1:0] MEMDest,
    input  logic             EXRegWrite,
    input  logic             MEMRegWrite,
    input  logic [1:0]       EXMemRead,
    input  logic [1:0]       MEMMemRead,
    input  logic             MemBusy,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDStall,
    output logic             PipeEn,
    output logic             IFFlush,
    output logic [CNT_W-1:0] StallCycles
);

    typedef enum logic [1:0] {RUN, STALL, FREEZE} state_t;

    state_t state, state_n;
    logic   remain, remain_n;
    logic   ret, ret_n;       // 1: freeze was entered from STALL
    logic   in_stall;

    logic hit_ex_rs, hit_ex_rt, hit_mem_rs, hit_mem_rt;
    logic hit_ex, hit_mem, ex_load, mem_load;
    logic [1:0] need;

    assign hit_ex_rs  = UsesRs && (RsID != '0) && (RsID == EXDest)  && EXRegWrite;
    assign hit_ex_rt  = UsesRt && (RtID != '0) && (RtID == EXDest)  && EXRegWrite;
    assign hit_mem_rs = UsesRs && (RsID != '0) && (RsID == MEMDest) && MEMRegWrite;
    assign hit_mem_rt = UsesRt && (RtID != '0) && (RtID == MEMDest) && MEMRegWrite;
    assign hit_ex     = hit_ex_rs  || hit_ex_rt;
    assign hit_mem    = hit_mem_rs || hit_mem_rt;
    assign ex_load    = |EXMemRead;
    assign mem_load   = |MEMMemRead;

    always_comb begin
        need = 2'd0;
        if (IDBranch && hit_ex && ex_load)
            need = 2'd2;
        else if ((ex_load && hit_ex) || (IDBranch && hit_ex) || (IDBranch && hit_mem && mem_load))
            need = 2'd1;
    end

    // A FREEZE cycle with MemBusy low already behaves as the saved state, so a
    // busy window of N cycles costs exactly N disabled cycles.
    always_comb begin
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        IDStall   = 1'b0;
        PipeEn    = 1'b1;
        IFFlush   = 1'b0;
        state_n   = state;
        remain_n  = remain;
        ret_n     = ret;
        in_stall  = (state == STALL) || ((state == FREEZE) && ret);

        if (MemBusy) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            PipeEn    = 1'b0;
            state_n   = FREEZE;
            ret_n     = in_stall;
        end else if (in_stall) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDStall   = 1'b1;
            // STALL is only ever entered with remain=1, so one cycle finishes it
            state_n   = RUN;
            remain_n  = 1'b0;
        end else if (need != 2'd0) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDStall   = 1'b1;
            state_n   = (need == 2'd2) ? STALL : RUN;
            remain_n  = (need == 2'd2);
        end else begin
            IFFlush   = BranchTaken;
            state_n   = RUN;
        end

        if (Rst) begin
            PCWrite   = 1'b1;
            IFIDWrite = 1'b1;
            IDStall   = 1'b0;
            PipeEn    = 1'b1;
            IFFlush   = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= RUN;
            remain      <= 1'b0;
            ret         <= 1'b0;
            StallCycles <= '0;
        end else begin
            state  <= state_n;
            remain <= remain_n;
            ret    <= ret_n;
            if (IDStall && (StallCycles != {CNT_W{1'b1}}))
                StallCycles <= StallCycles + 1'b1;
        end
    end

endmodule
